// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
// Memory message layout and sizing helpers for the mem cmd/resp arbiter slice.
// The message struct stands in for the BedRock CCE mem message used by the rest of the ME.
package bp_me_mem_cmd_arbiter_pkg;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef struct packed {
    bp_mem_msg_e  msg_type;
    logic [39:0]  addr;
    logic [2:0]   size;
    logic [63:0]  data;
  } bp_mem_msg_s;

  localparam int mem_msg_width_lp = $bits(bp_mem_msg_s);

  // Index width that stays at least one bit even for a single entry.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bp_me_mem_cmd_arbiter_tag_fifo.sv
// Small 1-read/1-write FIFO holding the requester id of every issued command,
// so responses (returned in command order) can be steered back to their issuer.
module bp_me_mem_cmd_arbiter_tag_fifo
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
)
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp   = safe_clog2(els_p);
  localparam int count_width_lp = width_of(els_p);

  logic [width_p-1:0]        storage [els_p];
  logic [ptr_width_lp-1:0]   wptr, rptr;
  logic [count_width_lp-1:0] count;
  logic                      push, pop;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count != count_width_lp'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = storage[rptr];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (push) storage[wptr] <= data_i;
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one mem cmd/resp channel pair among several requesters: round-robin on
// commands, in-order return of responses to whichever requester issued them.
module bp_me_mem_cmd_arbiter
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = 4,
  parameter int msg_width_p       = mem_msg_width_lp
)
(
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_ready_o,

  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i,

  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o
);

  localparam int id_width_lp = safe_clog2(num_req_p);

  logic [id_width_lp-1:0]   rr_ptr, grant, rot_idx, tag_head;
  logic [2*num_req_p-1:0]   req_dbl;
  logic [num_req_p-1:0]     req_rot;
  logic [id_width_lp:0]     grant_sum;
  logic                     tag_ready, tag_v, cmd_hs, resp_hs, active;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    req_dbl = {req_cmd_v_i, req_cmd_v_i};
    req_rot = req_dbl[rr_ptr +: num_req_p];
    rot_idx = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = id_width_lp'(i);
    end
    grant_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
    if (grant_sum >= (id_width_lp + 1)'(num_req_p))
      grant = id_width_lp'(grant_sum - (id_width_lp + 1)'(num_req_p));
    else
      grant = id_width_lp'(grant_sum);
  end

  assign active      = ~reset_i;
  assign mem_cmd_o   = req_cmd_i[grant*msg_width_p +: msg_width_p];
  assign mem_cmd_v_o = active & (|req_cmd_v_i) & tag_ready;
  assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    req_cmd_ready_o        = '0;
    req_cmd_ready_o[grant] = active & mem_cmd_ready_i & tag_ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_ptr <= '0;
    else if (cmd_hs)
      rr_ptr <= (grant == id_width_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
  end

  assign req_resp_o      = mem_resp_i;
  assign resp_hs         = active & mem_resp_v_i & tag_v & req_resp_yumi_i[tag_head];
  assign mem_resp_yumi_o = resp_hs;

  always_comb begin
    req_resp_v_o = '0;
    if (active & mem_resp_v_i & tag_v) req_resp_v_o[tag_head] = 1'b1;
  end

  bp_me_mem_cmd_arbiter_tag_fifo #(
    .width_p (id_width_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (grant),
    .v_i     (cmd_hs),
    .ready_o (tag_ready),
    .data_o  (tag_head),
    .v_o     (tag_v),
    .yumi_i  (resp_hs)
  );

`ifndef SYNTHESIS
  // A response with no outstanding tag means the memory side is out of sync.
  resp_without_tag: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_v_i && !tag_v));
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Scoreboard bench: expected owners are queued as commands are accepted and
// popped as responses come back, checking round-robin, flow control and routing.
module tb_bp_me_mem_cmd_arbiter;
  import bp_me_mem_cmd_arbiter_pkg::*;

  localparam int NumReq = 2;
  localparam int MaxOut = 4;
  localparam int MsgW   = mem_msg_width_lp;

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [NumReq*MsgW-1:0] req_cmd_i;
  logic [NumReq-1:0]      req_cmd_v_i;
  logic [NumReq-1:0]      req_cmd_ready_o;
  logic [MsgW-1:0]        req_resp_o;
  logic [NumReq-1:0]      req_resp_v_o;
  logic [NumReq-1:0]      req_resp_yumi_i;
  logic [MsgW-1:0]        mem_cmd_o;
  logic                   mem_cmd_v_o;
  logic                   mem_cmd_ready_i;
  logic [MsgW-1:0]        mem_resp_i;
  logic                   mem_resp_v_i;
  logic                   mem_resp_yumi_o;

  bp_mem_msg_s cmd0, cmd1, resp_msg;
  int          exp_q[$];
  int          rr_ptr_model;
  int          resp_num;
  int          compare_count;
  int          mismatch_count;

  always #5 clk = ~clk;

  assign req_cmd_i  = {cmd1, cmd0};
  assign mem_resp_i = resp_msg;

  bp_me_mem_cmd_arbiter #(
    .num_req_p         (NumReq),
    .max_outstanding_p (MaxOut)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_cmd_i       (req_cmd_i),
    .req_cmd_v_i     (req_cmd_v_i),
    .req_cmd_ready_o (req_cmd_ready_o),
    .req_resp_o      (req_resp_o),
    .req_resp_v_o    (req_resp_v_o),
    .req_resp_yumi_i (req_resp_yumi_i),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o)
  );

  function automatic bp_mem_msg_s mkMsg(input bp_mem_msg_e t, input logic [39:0] addr,
                                        input logic [63:0] data);
    bp_mem_msg_s m;
    m.msg_type = t;
    m.addr     = addr;
    m.size     = 3'd3;
    m.data     = data;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One cycle: offer commands in v, optionally present the next in-order response.
  task automatic applyStimulus(input logic [1:0] v, input bit give_resp, input bit give_yumi);
    int          g;
    int          owner;
    bit          accept;
    bit          resp_on;
    logic [1:0]  yumi;
    @(negedge clk);
    req_cmd_v_i     = v;
    mem_cmd_ready_i = 1'b1;
    yumi            = 2'b00;
    owner           = 0;
    resp_on         = 1'b0;
    if (give_resp) begin
      if (exp_q.size() == 0) begin
        checkOutput("resp_expected_outstanding", 0, 1);
      end else begin
        resp_on  = 1'b1;
        owner    = exp_q[0];
        resp_num++;
        resp_msg = mkMsg(e_mem_rd, 40'h0, 64'hD00D_0000 + 64'(resp_num));
        if (give_yumi) yumi[owner] = 1'b1;
      end
    end
    mem_resp_v_i    = resp_on;
    req_resp_yumi_i = yumi;
    #1;
    g = -1;
    for (int i = 0; i < NumReq; i++) begin
      int idx;
      idx = (rr_ptr_model + i) % NumReq;
      if (g < 0 && v[idx]) g = idx;
    end
    accept = (g >= 0) && (exp_q.size() < MaxOut);
    if (v != 2'b00) begin
      checkOutput("mem_cmd_v", mem_cmd_v_o, accept);
      checkOutput("cmd_ready", req_cmd_ready_o, accept ? (2'b01 << g) : 2'b00);
      if (accept) checkOutput("mem_cmd_payload", mem_cmd_o, (g == 0) ? cmd0 : cmd1);
    end
    if (resp_on) begin
      checkOutput("resp_v_route", req_resp_v_o, 2'b01 << owner);
      checkOutput("resp_payload", req_resp_o, resp_msg);
      checkOutput("mem_resp_yumi", mem_resp_yumi_o, give_yumi);
    end else begin
      checkOutput("resp_v_idle", req_resp_v_o, 2'b00);
    end
    @(posedge clk);
    if (resp_on && give_yumi) void'(exp_q.pop_front());
    if (accept) begin
      exp_q.push_back(g);
      rr_ptr_model = (g + 1) % NumReq;
    end
  endtask

  // Hold reset with every input asserted; all handshake outputs must stay low.
  task automatic resetCycle();
    @(negedge clk);
    reset_i         = 1'b1;
    req_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b1;
    req_resp_yumi_i = 2'b11;
    #1;
    checkOutput("rst_mem_cmd_v", mem_cmd_v_o, 0);
    checkOutput("rst_cmd_ready", req_cmd_ready_o, 0);
    checkOutput("rst_resp_v", req_resp_v_o, 0);
    checkOutput("rst_mem_resp_yumi", mem_resp_yumi_o, 0);
    @(posedge clk);
    exp_q.delete();
    rr_ptr_model = 0;
    @(negedge clk);
    reset_i         = 1'b0;
    req_cmd_v_i     = 2'b00;
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compare_count   = 0;
    mismatch_count  = 0;
    resp_num        = 0;
    rr_ptr_model    = 0;
    reset_i         = 1'b1;
    req_cmd_v_i     = 2'b00;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = 2'b00;
    cmd0            = mkMsg(e_mem_rd, 40'h00_8000_0000, 64'h0);
    cmd1            = mkMsg(e_mem_wr, 40'h00_8000_0040, 64'hCAFE_0001);
    resp_msg        = '0;

    resetCycle();

    // Lone read from requester 0, then its response.
    applyStimulus(2'b01, 0, 0);
    applyStimulus(2'b00, 1, 1);

    // Both requesters always valid: alternating grants until the tag FIFO fills.
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b11, 1, 1);
    applyStimulus(2'b11, 0, 0);

    // Owner withholds yumi, then everything drains in order.
    applyStimulus(2'b00, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1, 1);

    // Write from requester 0 then uncached read from requester 1.
    cmd0 = mkMsg(e_mem_wr,    40'h00_8000_0100, 64'h1234_5678);
    cmd1 = mkMsg(e_mem_uc_rd, 40'h00_0010_0000, 64'h0);
    applyStimulus(2'b01, 0, 0);
    applyStimulus(2'b10, 0, 0);
    applyStimulus(2'b00, 1, 0);
    applyStimulus(2'b00, 1, 1);
    applyStimulus(2'b00, 1, 1);

    // Reset with three commands outstanding.
    cmd0 = mkMsg(e_mem_uc_wr, 40'h00_0020_0000, 64'hBEEF);
    cmd1 = mkMsg(e_mem_rd,    40'h00_8000_0200, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 0, 0);
    resetCycle();
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1, 1);
    applyStimulus(2'b10, 0, 0);
    applyStimulus(2'b00, 1, 1);

    @(negedge clk);
    req_cmd_v_i     = 2'b00;
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = 2'b00;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
